gate_self_test: RTL and testbench

//  Stimulus/check sequencer that sits on both sides of the 7-output logic gate block.

---
 rtl/gate_self_test.sv | 189 ++++++++++++++++++
 tb/tb_gate_self_test.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gate_self_test.sv
// Self-test sequencer for the 7-output logic gate block: sweeps (a,b) through all
// four vectors, compares y_in with the truth table, and reports pass/err count/mask.
// Optional macro GATE_ST_FIRST_FAIL_EN adds first-failure capture ports.
module gate_self_test #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  output logic             a_out,
  output logic             b_out,
  input  logic [6:0]       y_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [CNT_W-1:0] err_cnt_out,
  output logic [6:0]       err_mask_out
`ifdef GATE_ST_FIRST_FAIL_EN
  ,
  output logic             first_fail_valid_out,
  output logic [1:0]       first_fail_vec_out,
  output logic [6:0]       first_fail_y_out
`endif
);

  localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [PASS_W-1:0]  pass_idx_q, pass_idx_d;
  logic [1:0]         ab_q, ab_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [6:0]         err_mask_q, err_mask_d;
`ifdef GATE_ST_FIRST_FAIL_EN
  logic               ff_valid_q, ff_valid_d;
  logic [1:0]         ff_vec_q, ff_vec_d;
  logic [6:0]         ff_y_q, ff_y_d;
`endif

  logic [6:0] exp_y;
  logic [6:0] diff;
  logic       mismatch;

  function automatic logic [6:0] gate_truth(input logic a, input logic b);
    return {~(a | b), ~(a & b), ~(a ^ b), a ^ b, ~a, a | b, a & b};
  endfunction

  always_comb begin
    exp_y    = gate_truth(ab_q[1], ab_q[0]);
    diff     = y_in ^ exp_y;
    mismatch = |diff;
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    pass_idx_d = pass_idx_q;
    ab_d       = ab_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    err_mask_d = err_mask_q;
`ifdef GATE_ST_FIRST_FAIL_EN
    ff_valid_d = ff_valid_q;
    ff_vec_d   = ff_vec_q;
    ff_y_d     = ff_y_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d    = S_SETTLE;
          settle_d   = '0;
          pass_idx_d = '0;
          ab_d       = '0;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          err_cnt_d  = '0;
          err_mask_d = '0;
`ifdef GATE_ST_FIRST_FAIL_EN
          ff_valid_d = 1'b0;
          ff_vec_d   = '0;
          ff_y_d     = '0;
`endif
        end
      end
      S_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d  = S_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          err_mask_d = err_mask_q | diff;
`ifdef GATE_ST_FIRST_FAIL_EN
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_vec_d   = ab_q;
            ff_y_d     = y_in;
          end
`endif
        end
        if (ab_q == 2'd3 && pass_idx_q == PASS_W'(PASSES - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // pass reflects the count including this final sample
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d = S_SETTLE;
          ab_d    = ab_q + 1'b1;
          if (ab_q == 2'd3) pass_idx_d = pass_idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      settle_q   <= '0;
      pass_idx_q <= '0;
      ab_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_mask_q <= '0;
`ifdef GATE_ST_FIRST_FAIL_EN
      ff_valid_q <= 1'b0;
      ff_vec_q   <= '0;
      ff_y_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      pass_idx_q <= pass_idx_d;
      ab_q       <= ab_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      err_mask_q <= err_mask_d;
`ifdef GATE_ST_FIRST_FAIL_EN
      ff_valid_q <= ff_valid_d;
      ff_vec_q   <= ff_vec_d;
      ff_y_q     <= ff_y_d;
`endif
    end
  end

  assign a_out        = ab_q[1];
  assign b_out        = ab_q[0];
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign pass_out     = pass_q;
  assign err_cnt_out  = err_cnt_q;
  assign err_mask_out = err_mask_q;
`ifdef GATE_ST_FIRST_FAIL_EN
  assign first_fail_valid_out = ff_valid_q;
  assign first_fail_vec_out   = ff_vec_q;
  assign first_fail_y_out     = ff_y_q;
`endif

endmodule

// File: tb/tb_gate_self_test.sv
// Randomized bench for gate_self_test: a faultable gate model drives y_in and a
// run-level reference computes the expected count, mask, pass and latency.
module tb_gate_self_test;

  localparam int unsigned S   = 2;
  localparam int unsigned P   = 2;
  localparam int unsigned W   = 2;
  localparam int unsigned LAT = 1 + P * 4 * (S + 1);
  localparam int unsigned SAT = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         a, b, busy, done, pass;
  logic [W-1:0] cnt;
  logic [6:0]   mask, y;
  logic [6:0]   and_m = '1;
  logic [6:0]   or_m  = '0;
  logic [6:0]   xor_tab [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] truth(input logic ta, input logic tb);
    logic [6:0] r;
    r[0] = ta & tb;
    r[1] = ta | tb;
    r[2] = ~ta;
    r[3] = ta ^ tb;
    r[4] = ~(ta ^ tb);
    r[5] = ~(ta & tb);
    r[6] = ~(ta | tb);
    return r;
  endfunction

  function automatic logic [6:0] faulty(input logic [1:0] v);
    return ((truth(v[1], v[0]) & and_m) | or_m) ^ xor_tab[v];
  endfunction

  assign y = faulty({a, b});

  gate_self_test #(.SETTLE_CYCLES(S), .PASSES(P), .CNT_W(W)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .start_in     (start),
    .a_out        (a),
    .b_out        (b),
    .y_in         (y),
    .busy_out     (busy),
    .done_out     (done),
    .pass_out     (pass),
    .err_cnt_out  (cnt),
    .err_mask_out (mask)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_fault(input int mode);
    and_m = '1;
    or_m  = '0;
    for (int i = 0; i < 4; i++) xor_tab[i] = '0;
    case (mode)
      1: and_m[$urandom_range(0, 6)] = 1'b0;
      2: or_m[$urandom_range(0, 6)] = 1'b1;
      3: for (int i = 0; i < 4; i++) xor_tab[i] = $urandom_range(0, 1) ? 7'($urandom) : 7'h00;
      4: for (int i = 0; i < 4; i++) xor_tab[i] = 7'h7F;
      5: and_m[3] = 1'b0;
      default: ;
    endcase
  endtask

  task automatic run(input int mode, input bit poke);
    int          k, poke_at, n_bad;
    bit          busy_ok;
    logic [6:0]  m_mask, g, yy;
    logic [1:0]  vb;
    int unsigned exp_cnt;
    set_fault(mode);
    n_bad  = 0;
    m_mask = '0;
    for (int p = 0; p < int'(P); p++)
      for (int v = 0; v < 4; v++) begin
        vb = 2'(v);
        g  = truth(vb[1], vb[0]);
        yy = faulty(vb);
        if (yy != g) begin
          n_bad++;
          m_mask |= yy ^ g;
        end
      end
    exp_cnt = (n_bad > int'(SAT)) ? SAT : n_bad;
    poke_at = $urandom_range(2, LAT - 2);

    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    k       = 1;
    busy_ok = 1'b1;
    while (!done && k < int'(LAT) + 20) begin
      if (!busy) busy_ok = 1'b0;
      start = poke && (k == poke_at);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    check("latency", k, LAT);
    check("busy_run", busy_ok, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("pass", pass, n_bad == 0);
    check("err_cnt", cnt, exp_cnt);
    check("err_mask", mask, m_mask);
    check("ab_hold", {a, b}, 2'b11);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("hold_after", {busy, pass, cnt, mask}, {1'b0, n_bad == 0, W'(exp_cnt), m_mask});
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin
    int k, n_done;
    for (int i = 0; i < 4; i++) xor_tab[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", {a, b, busy, done, pass, cnt, mask}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", {a, b, busy, done, pass, cnt, mask}, '0);

    for (int i = 0; i < 18; i++) run(i % 6, (i % 3) == 1);

    // reset mid-run aborts without done
    set_fault(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outs", {a, b, busy, done, pass, cnt, mask}, '0);
    n_done = 0;
    repeat (LAT + 5) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("midrst_nodone", n_done, 0);

    // start held high restarts on the first IDLE cycle
    set_fault(0);
    start = 1'b1;
    k = 0;
    while (!done && k < int'(LAT) + 20) begin
      @(negedge clk);
      k++;
    end
    check("held_done", done, 1'b1);
    @(negedge clk);
    check("held_idle", busy, 1'b0);
    @(negedge clk);
    check("held_restart", busy, 1'b1);
    start = 1'b0;
    k = 0;
    while (!done && k < int'(LAT) + 20) begin
      @(negedge clk);
      k++;
    end
    check("held_done2", {done, pass}, 2'b11);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
